// File: rtl/io_bridge.sv
// ---------------------------------------------------------------------------
// io_bridge
//
// Sits between the CPU's MEM-stage data port and the 64 KB data memory.
// Three word addresses near the top of the address space are I/O registers
// and never reach data memory. All other addresses pass straight through.
// The bridge also drives the board peripherals: debounced switches, LEDs and
// an 8-digit multiplexed seven-segment display.
//
// Address map (full 32-bit compare, word access only):
//   0xFFFFF000  DISP  read/write, 8 hex digits shown on the display
//   0xFFFFF060  LED   read/write, bits [23:0] drive the LEDs
//   0xFFFFF070  SW    read-only, {8'h0, debounced switches}
//
// Parameters:
//   SCAN_DIV    clk cycles each display digit stays lit
//   DEB_CYCLES  stable cycles needed before a switch change is accepted (>= 2)
//
// Ports:
//   clk     in   system clock, all state changes on its rising edge
//   rst     in   asynchronous active-high reset
//   addr    in   CPU data address
//   dm_we   in   CPU store enable
//   din     in   CPU store data
//   dm_rd0  in   read data coming back from data memory
//   dm_rd   out  read data returned to the CPU
//   dm_we0  out  write enable forwarded to data memory
//   sw      in   raw board switches, asynchronous to clk
//   led     out  board LEDs, active-high
//   led_en  out  digit enables, active-low, exactly one low
//   seg     out  segments, active-low, seg[0]=a .. seg[6]=g, seg[7]=dp
// ---------------------------------------------------------------------------
module io_bridge #(
    parameter int SCAN_DIV   = 25000,
    parameter int DEB_CYCLES = 250000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        dm_we,
    input  logic [31:0] din,
    input  logic [31:0] dm_rd0,
    output logic [31:0] dm_rd,
    output logic        dm_we0,
    input  logic [23:0] sw,
    output logic [23:0] led,
    output logic [7:0]  led_en,
    output logic [7:0]  seg
);

    localparam logic [31:0] ADDR_DISP = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_LED  = 32'hFFFF_F060;
    localparam logic [31:0] ADDR_SW   = 32'hFFFF_F070;

    localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DBW = $clog2(DEB_CYCLES);

    localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);
    localparam logic [DBW-1:0] DEB_LAST  = DBW'(DEB_CYCLES - 1);

    logic        isDisp;
    logic        isLed;
    logic        isSw;
    logic        ioHit;

    logic [31:0] disp_q,     disp_d;
    logic [23:0] led_q,      led_d;
    logic [23:0] swS1_q;
    logic [23:0] swS2_q;
    logic [23:0] cand_q,     cand_d;
    logic [DBW-1:0] debCnt_q, debCnt_d;
    logic [23:0] swStable_q, swStable_d;
    logic [SCW-1:0] scanCnt_q, scanCnt_d;
    logic [2:0]  dig_q,      dig_d;

    logic [3:0]  nibble;
    logic [6:0]  segs;

    // Address decode and routing to data memory. This is purely combinational
    // so that it keeps working while reset is held. A store to SW matches the
    // I/O window but writes nothing, so it is silently dropped.
    always_comb begin
        isDisp = (addr == ADDR_DISP);
        isLed  = (addr == ADDR_LED);
        isSw   = (addr == ADDR_SW);
        ioHit  = isDisp | isLed | isSw;
        dm_we0 = dm_we & ~ioHit;

        dm_rd = dm_rd0;
        if (isDisp) begin
            dm_rd = disp_q;
        end else if (isLed) begin
            dm_rd = {8'h00, led_q};
        end else if (isSw) begin
            dm_rd = {8'h00, swStable_q};
        end
    end

    // Next-state logic for the writable registers, the switch debouncer and
    // the display scan. The debouncer treats the 24 synchronized switch bits
    // as one word: any bit change restarts the count. Once the count reaches
    // its last value it holds there and keeps reloading the stable output.
    always_comb begin
        disp_d = disp_q;
        led_d  = led_q;
        if (dm_we && isDisp) begin
            disp_d = din;
        end
        if (dm_we && isLed) begin
            led_d = din[23:0];
        end

        cand_d     = cand_q;
        debCnt_d   = debCnt_q;
        swStable_d = swStable_q;
        if (swS2_q != cand_q) begin
            cand_d   = swS2_q;
            debCnt_d = '0;
        end else if (debCnt_q == DEB_LAST) begin
            swStable_d = cand_q;
        end else begin
            debCnt_d = debCnt_q + 1'b1;
        end

        scanCnt_d = scanCnt_q + 1'b1;
        dig_d     = dig_q;
        if (scanCnt_q == SCAN_LAST) begin
            scanCnt_d = '0;
            dig_d     = dig_q + 3'd1;
        end
    end

    // All state. The two synchronizer flops sample the raw switches before
    // anything else looks at them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q     <= '0;
            led_q      <= '0;
            swS1_q     <= '0;
            swS2_q     <= '0;
            cand_q     <= '0;
            debCnt_q   <= '0;
            swStable_q <= '0;
            scanCnt_q  <= '0;
            dig_q      <= '0;
        end else begin
            disp_q     <= disp_d;
            led_q      <= led_d;
            swS1_q     <= sw;
            swS2_q     <= swS1_q;
            cand_q     <= cand_d;
            debCnt_q   <= debCnt_d;
            swStable_q <= swStable_d;
            scanCnt_q  <= scanCnt_d;
            dig_q      <= dig_d;
        end
    end

    // Seven-segment decode of the digit currently being scanned. Digit 0 is
    // the least significant nibble of DISP. The table is active-low and the
    // decimal point is never lit.
    always_comb begin
        nibble = disp_q[{dig_q, 2'b00} +: 4];
        segs   = 7'h7F;
        unique case (nibble)
            4'h0: segs = 7'h40;
            4'h1: segs = 7'h79;
            4'h2: segs = 7'h24;
            4'h3: segs = 7'h30;
            4'h4: segs = 7'h19;
            4'h5: segs = 7'h12;
            4'h6: segs = 7'h02;
            4'h7: segs = 7'h78;
            4'h8: segs = 7'h00;
            4'h9: segs = 7'h10;
            4'hA: segs = 7'h08;
            4'hB: segs = 7'h03;
            4'hC: segs = 7'h46;
            4'hD: segs = 7'h21;
            4'hE: segs = 7'h06;
            4'hF: segs = 7'h0E;
        endcase
        seg    = {1'b1, segs};
        led_en = ~(8'b1 << dig_q);
        led    = led_q;
    end

endmodule

// File: tb/tb_io_bridge.sv
// ---------------------------------------------------------------------------
// tb_io_bridge
//
// Drives io_bridge with a mix of directed and random CPU accesses and switch
// activity, and compares every output against a behavioural model each cycle.
// The model keeps only the architectural register values, a cycle count since
// reset (from which the scanned digit is derived arithmetically) and a
// run-length count of how long the synchronized switch word has been steady.
// ---------------------------------------------------------------------------
module tb_io_bridge;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 4;

    localparam logic [31:0] A_DISP = 32'hFFFF_F000;
    localparam logic [31:0] A_LED  = 32'hFFFF_F060;
    localparam logic [31:0] A_SW   = 32'hFFFF_F070;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic        dm_we = 1'b0;
    logic [31:0] din = '0;
    logic [31:0] dm_rd0 = '0;
    logic [31:0] dm_rd;
    logic        dm_we0;
    logic [23:0] sw = '0;
    logic [23:0] led;
    logic [7:0]  led_en;
    logic [7:0]  seg;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    logic [31:0] mDisp;
    logic [23:0] mLed;
    logic [23:0] mStable;
    logic [23:0] mSwHist1;
    logic [23:0] mSwHist2;
    logic [23:0] mRunVal;
    int          mRunLen;
    int          mTick;

    io_bridge #(
        .SCAN_DIV   (SCAN_DIV),
        .DEB_CYCLES (DEB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .addr   (addr),
        .dm_we  (dm_we),
        .din    (din),
        .dm_rd0 (dm_rd0),
        .dm_rd  (dm_rd),
        .dm_we0 (dm_we0),
        .sw     (sw),
        .led    (led),
        .led_en (led_en),
        .seg    (seg)
    );

    // 100 MHz free-running clock
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Active-low seven-segment pattern for a hex digit, dp off
    function automatic logic [7:0] hexSeg(input logic [3:0] n);
        logic [7:0] tbl [16];
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return tbl[n];
    endfunction

    function automatic int modelDig();
        return (mTick / SCAN_DIV) % 8;
    endfunction

    function automatic logic [31:0] modelRead(input logic [31:0] a, input logic [31:0] memData);
        if (a == A_DISP) return mDisp;
        if (a == A_LED)  return {8'h00, mLed};
        if (a == A_SW)   return {8'h00, mStable};
        return memData;
    endfunction

    task automatic modelReset();
        mDisp    = '0;
        mLed     = '0;
        mStable  = '0;
        mSwHist1 = '0;
        mSwHist2 = '0;
        mRunVal  = '0;
        mRunLen  = 1;
        mTick    = 0;
    endtask

    // One rising edge worth of architectural behaviour. A switch value
    // becomes stable once the synchronized word has been seen unchanged on
    // DEB+1 consecutive edges (the reset value counts as the first sighting).
    task automatic modelEdge();
        logic [23:0] sample;
        if (dm_we && addr == A_DISP) mDisp = din;
        if (dm_we && addr == A_LED)  mLed  = din[23:0];
        sample   = mSwHist2;
        mSwHist2 = mSwHist1;
        mSwHist1 = sw;
        if (sample == mRunVal) begin
            if (mRunLen < 1000) mRunLen++;
        end else begin
            mRunVal = sample;
            mRunLen = 1;
        end
        if (mRunLen >= DEB + 1) mStable = mRunVal;
        mTick++;
    endtask

    // Apply one cycle of inputs, check every output at the falling edge,
    // then advance the model with the rising edge.
    task automatic applyStimulus(input logic [31:0] a, input logic we, input logic [31:0] d,
                                 input logic [31:0] rd0, input logic [23:0] s);
        logic hit;
        int   dg;
        addr   = a;
        dm_we  = we;
        din    = d;
        dm_rd0 = rd0;
        sw     = s;
        @(negedge clk);
        hit = (a == A_DISP) || (a == A_LED) || (a == A_SW);
        dg  = modelDig();
        checkOutput("dm_we0", {31'b0, dm_we0}, {31'b0, we & ~hit});
        checkOutput("dm_rd", dm_rd, modelRead(a, rd0));
        checkOutput("led", {8'h0, led}, {8'h0, mLed});
        checkOutput("led_en", {24'h0, led_en}, {24'h0, 8'hFF ^ (8'h01 << dg)});
        checkOutput("seg", {24'h0, seg}, {24'h0, hexSeg(mDisp[dg*4 +: 4])});
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    // Asynchronous assert, checks during reset, release just after an edge.
    task automatic applyReset();
        rst = 1'b1;
        #1;
        checkOutput("rstLedEn", {24'h0, led_en}, 32'h0000_00FE);
        checkOutput("rstSeg", {24'h0, seg}, 32'h0000_00C0);
        checkOutput("rstLed", {8'h0, led}, 32'h0);
        checkOutput("rstWe0", {31'b0, dm_we0}, {31'b0, dm_we & ~((addr == A_DISP) || (addr == A_LED) || (addr == A_SW))});
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        int found;
        int holdLeft;
        logic [23:0] swVal;
        logic [31:0] a;
        logic [31:0] d;

        #3;
        applyReset();

        // Reset state, SW read returns 0
        applyStimulus(A_SW, 1'b0, 32'h0, 32'h1111_1111, 24'h0);
        for (int i = 0; i < 6; i++) applyStimulus(32'h0, 1'b0, 32'h0, 32'h0, 24'h0);

        // Routing: LED store, memory store, memory read, dropped SW store
        applyStimulus(A_LED, 1'b1, 32'h00AB_CDEF, 32'h0, 24'h0);
        checkOutput("ledWrite", {8'h0, led}, 32'h00AB_CDEF);
        applyStimulus(32'h0000_0010, 1'b1, 32'h5555_AAAA, 32'h0, 24'h0);
        applyStimulus(32'h0000_0010, 1'b0, 32'h0, 32'hCAFE_F00D, 24'h0);
        applyStimulus(A_SW, 1'b1, 32'h00FF_FFFF, 32'h0, 24'h0);
        applyStimulus(A_SW, 1'b0, 32'h0, 32'h0, 24'h0);
        checkOutput("swStoreDropped", dm_rd, 32'h0);

        // Display scan over a full digit rotation and the wrap
        applyStimulus(A_DISP, 1'b1, 32'h1234_A6F8, 32'h0, 24'h0);
        for (int i = 0; i < 40; i++) applyStimulus(A_DISP, 1'b0, 32'h0, 32'h0, 24'h0);

        // Debounce accept: edge count from the change to SW read showing it
        found = -1;
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(A_SW, 1'b0, 32'h0, 32'h0, 24'h000005);
            #1;
            if (found < 0 && dm_rd == 32'h0000_0005) found = i;
        end
        checkOutput("debLatency", found, 32'd7);

        // Debounce reject: 3-cycle pulse back from a settled 0
        for (int i = 0; i < 10; i++) applyStimulus(A_SW, 1'b0, 32'h0, 32'h0, 24'h0);
        for (int i = 0; i < 3; i++)  applyStimulus(A_SW, 1'b0, 32'h0, 32'h0, 24'hFF_FFFF);
        for (int i = 0; i < 20; i++) applyStimulus(A_SW, 1'b0, 32'h0, 32'h0, 24'h0);
        checkOutput("debReject", dm_rd, 32'h0);

        // Mid-operation reset at digit 5 with a debounce count in progress
        applyStimulus(A_LED, 1'b1, 32'h0012_3456, 32'h0, 24'h0);
        applyStimulus(A_DISP, 1'b1, 32'h8765_4321, 32'h0, 24'h0);
        for (int i = 0; i < 64 && (mTick % 32) != 20; i++) applyStimulus(32'h40, 1'b0, 32'h0, 32'h0, 24'h0);
        checkOutput("reachDig5", modelDig(), 32'd5);
        for (int i = 0; i < 3; i++) applyStimulus(32'h40, 1'b0, 32'h0, 32'h0, 24'h000123);
        applyReset();
        checkOutput("midRstLedEn", {24'h0, led_en}, 32'h0000_00FE);
        checkOutput("midRstLed", {8'h0, led}, 32'h0);
        applyStimulus(A_DISP, 1'b0, 32'h0, 32'h0, 24'h000123);
        applyStimulus(A_SW, 1'b0, 32'h0, 32'h0, 24'h000123);
        for (int i = 0; i < 12; i++) applyStimulus(A_SW, 1'b0, 32'h0, 32'h0, 24'h000123);
        checkOutput("postRstAccept", dm_rd, 32'h0000_0123);

        // Randomized traffic with held and glitchy switch activity
        holdLeft = 0;
        swVal    = 24'h0;
        for (int i = 0; i < 700; i++) begin
            if (holdLeft == 0) begin
                case ($urandom_range(0, 3))
                    0: swVal = 24'h0;
                    1: swVal = 24'h000005;
                    2: swVal = 24'hFF_FFFF;
                    default: swVal = 24'($urandom);
                endcase
                holdLeft = $urandom_range(1, 10);
            end
            holdLeft--;
            case ($urandom_range(0, 5))
                0: a = A_DISP;
                1: a = A_LED;
                2: a = A_SW;
                3: a = 32'h0000_0010;
                4: a = 32'hFFFF_F064;
                default: a = $urandom;
            endcase
            d = $urandom;
            applyStimulus(a, 1'($urandom_range(0, 1)), d, $urandom, swVal);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
